// File: rtl/apb4_completer.sv
// -----------------------------------------------------------------------------
// apb4_completer
//
// APB4 completer that bridges an APB requester to a register bank through a
// level request/acknowledge handshake. The block checks the address, issues
// one request per valid access and stretches the APB transfer with PREADY
// wait states until the register side acknowledges or the access times out.
//
// Behaviour summary:
//   - A setup phase (PSEL=1, PENABLE=0) seen in IDLE is captured and decoded.
//   - An address below BASE_ADDR, beyond the register window or not aligned
//     to the data width completes with zero wait states and PSLVERR=1.
//   - A write with PSTRB=0 completes with zero wait states as an OKAY no-op.
//   - Otherwise o_req is raised and held until i_ack or the timeout.
//   - PREADY is a one-cycle pulse; PRDATA/PSLVERR are only non-zero with it.
//
// Ports:
//   PCLK      in   clock, rising edge
//   PRESET    in   synchronous active-high reset
//   PSEL      in   APB select
//   PENABLE   in   APB access phase
//   PWRITE    in   1 = write, 0 = read
//   PADDR     in   byte address              [ADDR_WIDTH]
//   PWDATA    in   write data                [DATA_WIDTH]
//   PSTRB     in   write byte strobes        [BYTES]
//   PREADY    out  transfer complete (one-cycle pulse)
//   PRDATA    out  read data, valid with PREADY [DATA_WIDTH]
//   PSLVERR   out  transfer error, valid with PREADY
//   o_req     out  register request, held until i_ack or timeout
//   o_wr      out  1 = write, 0 = read
//   o_addr    out  register index            [IDX_W]
//   o_wdata   out  write data                [DATA_WIDTH]
//   o_wstrb   out  byte enables, zero on reads [BYTES]
//   i_ack     in   register side done (looked at only while o_req = 1)
//   i_rdata   in   read data, valid with i_ack [DATA_WIDTH]
//   i_err     in   register-side error, valid with i_ack
// -----------------------------------------------------------------------------
module apb4_completer #(
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int          NUM_REGS   = 16,
  parameter int          TIMEOUT    = 15,
  localparam int         BYTES      = DATA_WIDTH / 8,
  localparam int         IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [BYTES-1:0]      PSTRB,
  output logic                  PREADY,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PSLVERR,
  output logic                  o_req,
  output logic                  o_wr,
  output logic [IDX_W-1:0]      o_addr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [BYTES-1:0]      o_wstrb,
  input  logic                  i_ack,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  i_err
);

  // Address decode constants. The decode works one bit wider than PADDR so
  // that PADDR - BASE_ADDR can never silently wrap into the valid window.
  localparam int                AL         = $clog2(BYTES);
  localparam logic [ADDR_WIDTH:0] BASE_EXT = (ADDR_WIDTH+1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] SPAN_EXT = (ADDR_WIDTH+1)'(NUM_REGS * BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);

  // Timeout counter sizing. The counter holds the number of completed WAIT
  // cycles, so it only has to reach TIMEOUT-1 before the expiry compare.
  localparam int             CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit             TO_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_s;
  logic [CNT_W-1:0]      cnt_inc_s;

  // Next values for every registered output.
  logic                  pready_s;
  logic                  pslverr_s;
  logic [DATA_WIDTH-1:0] prdata_s;
  logic                  req_s;
  logic                  wr_s;
  logic [IDX_W-1:0]      addr_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic [BYTES-1:0]      wstrb_s;

  // Decode results for the address currently on PADDR.
  logic                  setup_s;
  logic [ADDR_WIDTH:0]   addr_ext_s;
  logic [ADDR_WIDTH:0]   offset_s;
  logic                  below_s;
  logic                  above_s;
  logic                  unalign_s;
  logic                  dec_err_s;
  logic [IDX_W-1:0]      idx_s;

  // Address decode and range/alignment checks for the setup phase.
  always_comb begin
    setup_s    = PSEL & ~PENABLE;
    addr_ext_s = {1'b0, PADDR};
    offset_s   = addr_ext_s - BASE_EXT;
    below_s    = (addr_ext_s < BASE_EXT);
    above_s    = (offset_s >= SPAN_EXT);
    unalign_s  = ((PADDR & ALIGN_MASK) != '0);
    dec_err_s  = below_s | above_s | unalign_s;
    idx_s      = IDX_W'(offset_s >> AL);
    cnt_inc_s  = cnt_r + CNT_W'(1);
  end

  // Next-state and next-output logic for the transfer FSM.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    pready_s  = 1'b0;
    pslverr_s = PSLVERR;
    prdata_s  = PRDATA;
    req_s     = o_req;
    wr_s      = o_wr;
    addr_s    = o_addr;
    wdata_s   = o_wdata;
    wstrb_s   = o_wstrb;

    case (state_r)
      ST_IDLE: begin
        req_s     = 1'b0;
        pslverr_s = 1'b0;
        prdata_s  = '0;
        // An access phase without a preceding setup phase is ignored here.
        if (setup_s) begin
          if (dec_err_s) begin
            state_s   = ST_RESP;
            pready_s  = 1'b1;
            pslverr_s = 1'b1;
          end else if (PWRITE && (PSTRB == '0)) begin
            // A write that enables no byte lanes is completed locally.
            state_s   = ST_RESP;
            pready_s  = 1'b1;
          end else begin
            state_s = ST_WAIT;
            req_s   = 1'b1;
            cnt_s   = '0;
            addr_s  = idx_s;
            wr_s    = PWRITE;
            wdata_s = PWRITE ? PWDATA : '0;
            wstrb_s = PWRITE ? PSTRB : '0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WAIT: begin
        req_s = 1'b1;
        cnt_s = cnt_inc_s;
        // An acknowledge in the expiry cycle still completes normally.
        if (i_ack) begin
          state_s   = ST_RESP;
          req_s     = 1'b0;
          pready_s  = 1'b1;
          pslverr_s = i_err;
          prdata_s  = (!o_wr && !i_err) ? i_rdata : '0;
        end else if (TO_EN && (cnt_inc_s == TO_VAL)) begin
          state_s   = ST_RESP;
          req_s     = 1'b0;
          pready_s  = 1'b1;
          pslverr_s = 1'b1;
          prdata_s  = '0;
        end else begin
          state_s = ST_WAIT;
        end
      end

      ST_RESP: begin
        // PREADY was high for this one cycle; always return to IDLE, even if
        // the requester has already dropped PSEL.
        state_s   = ST_IDLE;
        req_s     = 1'b0;
        pslverr_s = 1'b0;
        prdata_s  = '0;
      end

      default: begin
        state_s   = ST_IDLE;
        req_s     = 1'b0;
        pslverr_s = 1'b0;
        prdata_s  = '0;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
      o_req   <= 1'b0;
      o_wr    <= 1'b0;
      o_addr  <= '0;
      o_wdata <= '0;
      o_wstrb <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      PREADY  <= pready_s;
      PSLVERR <= pslverr_s;
      PRDATA  <= prdata_s;
      o_req   <= req_s;
      o_wr    <= wr_s;
      o_addr  <= addr_s;
      o_wdata <= wdata_s;
      o_wstrb <= wstrb_s;
    end
  end

endmodule
